// File: rtl/floatpkg.sv
// Shared single-precision float types, FSM state encoding and constants
// for the multi-cycle float subtractor.
package floatpkg;

    localparam int unsigned MANT_W = 24;

    localparam logic [7:0]  EXP_MAX = 8'd255;
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;

    typedef struct packed {
        logic        signal;
        logic [7:0]  exponent;
        logic [22:0] fraction;
    } float_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        ADD   = 3'd2,
        NORM  = 3'd3,
        DONE  = 3'd4
    } state_e;

    // Denormals flush to zero: the hidden bit exists only for exponent != 0.
    function automatic logic [MANT_W-1:0] mant_of(input float_t f);
        return (f.exponent == 8'd0) ? '0 : {1'b1, f.fraction};
    endfunction

endpackage

// File: rtl/float_norm_step.sv
// One left-normalize step: shift the mantissa up one bit, decrement the exponent.
module float_norm_step
    import floatpkg::*;
(
    input  logic [MANT_W-2:0] mant_in,
    input  logic [7:0]        exp_in,
    output logic [MANT_W-1:0] mant_c,
    output logic [7:0]        exp_c,
    output logic              hit_c,
    output logic              flush_c
);

    always_comb begin
        mant_c  = {mant_in, 1'b0};
        exp_c   = exp_in - 8'd1;
        hit_c   = mant_c[MANT_W-1];
        // Exponent 1 cannot be decremented without leaving the normal range.
        flush_c = (exp_in <= 8'd1);
    end

endmodule

// File: rtl/float_sub.sv
// Multi-cycle single-precision subtractor x - y with truncation, denormal
// flush and one-bit-per-cycle alignment and normalization.
module float_sub
    import floatpkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   in_valid,
    output logic   in_ready,
    input  float_t x,
    input  float_t y,
    output logic   out_valid,
    input  logic   out_ready,
    output float_t out,
    output logic   overflow,
    output logic   invalid
);

    state_e state_q, state_d;

    logic [MANT_W-1:0] ma_q, ma_d, mb_q, mb_d;
    logic [7:0]        ea_q, ea_d, eb_q, eb_d;
    logic              sa_q, sa_d, sb_q, sb_d;
    logic              special_q, special_d;

    float_t out_q, out_d;
    logic   out_valid_q, out_valid_d;
    logic   overflow_q, overflow_d;
    logic   invalid_q, invalid_d;

    logic [MANT_W:0]   sum_c;
    logic              sign_c;
    logic [MANT_W-1:0] norm_mant_c;
    logic [7:0]        norm_exp_c;
    logic              norm_hit_c;
    logic              norm_flush_c;

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign overflow  = overflow_q;
    assign invalid   = invalid_q;

    // Magnitude add/subtract on aligned mantissas; sign follows the larger one.
    always_comb begin
        sign_c = sa_q;
        if (sa_q == sb_q) begin
            sum_c = {1'b0, ma_q} + {1'b0, mb_q};
        end else if (ma_q >= mb_q) begin
            sum_c = {1'b0, ma_q - mb_q};
        end else begin
            sum_c  = {1'b0, mb_q - ma_q};
            sign_c = sb_q;
        end
    end

    float_norm_step u_norm (
        .mant_in (ma_q[MANT_W-2:0]),
        .exp_in  (ea_q),
        .mant_c  (norm_mant_c),
        .exp_c   (norm_exp_c),
        .hit_c   (norm_hit_c),
        .flush_c (norm_flush_c)
    );

    always_comb begin
        state_d    = state_q;
        ma_d       = ma_q;
        mb_d       = mb_q;
        ea_d       = ea_q;
        eb_d       = eb_q;
        sa_d       = sa_q;
        sb_d       = sb_q;
        special_d  = special_q;
        out_d      = out_q;
        overflow_d = overflow_q;
        invalid_d  = invalid_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    ma_d      = mant_of(x);
                    mb_d      = mant_of(y);
                    ea_d      = x.exponent;
                    eb_d      = y.exponent;
                    sa_d      = x.signal;
                    sb_d      = ~y.signal;
                    special_d = (x.exponent == EXP_MAX) || (y.exponent == EXP_MAX);
                    state_d   = (special_d || (x.exponent == y.exponent)) ? ADD : ALIGN;
                end
            end
            ALIGN: begin
                if (ea_q > eb_q) begin
                    if ((ea_q - eb_q) >= 8'd25) begin
                        mb_d = '0;
                        eb_d = ea_q;
                    end else begin
                        mb_d = mb_q >> 1;
                        eb_d = eb_q + 8'd1;
                    end
                end else begin
                    if ((eb_q - ea_q) >= 8'd25) begin
                        ma_d = '0;
                        ea_d = eb_q;
                    end else begin
                        ma_d = ma_q >> 1;
                        ea_d = ea_q + 8'd1;
                    end
                end
                if (ea_d == eb_d) begin
                    state_d = ADD;
                end
            end
            ADD: begin
                if (special_q) begin
                    out_d     = QNAN;
                    invalid_d = 1'b1;
                    state_d   = DONE;
                end else if (sum_c == '0) begin
                    out_d   = '0;
                    state_d = DONE;
                end else if (sum_c[MANT_W]) begin
                    if (ea_q == (EXP_MAX - 8'd1)) begin
                        out_d      = {sign_c, EXP_MAX, 23'd0};
                        overflow_d = 1'b1;
                    end else begin
                        out_d = {sign_c, ea_q + 8'd1, sum_c[MANT_W-1:1]};
                    end
                    state_d = DONE;
                end else if (!sum_c[MANT_W-1]) begin
                    ma_d    = sum_c[MANT_W-1:0];
                    sa_d    = sign_c;
                    state_d = NORM;
                end else begin
                    out_d   = {sign_c, ea_q, sum_c[MANT_W-2:0]};
                    state_d = DONE;
                end
            end
            NORM: begin
                if (norm_flush_c) begin
                    out_d   = '0;
                    state_d = DONE;
                end else begin
                    ma_d = norm_mant_c;
                    ea_d = norm_exp_c;
                    if (norm_hit_c) begin
                        out_d   = {sa_q, norm_exp_c, norm_mant_c[MANT_W-2:0]};
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    overflow_d = 1'b0;
                    invalid_d  = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ma_q        <= '0;
            mb_q        <= '0;
            ea_q        <= '0;
            eb_q        <= '0;
            sa_q        <= 1'b0;
            sb_q        <= 1'b0;
            special_q   <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            invalid_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ma_q        <= ma_d;
            mb_q        <= mb_d;
            ea_q        <= ea_d;
            eb_q        <= eb_d;
            sa_q        <= sa_d;
            sb_q        <= sb_d;
            special_q   <= special_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
            invalid_q   <= invalid_d;
        end
    end

endmodule
